// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth command link: baud timing, ASCII
// constants used by frame decoding, and the parser state encoding.
package bt_pkg;

    // Shared with the transmit side so both directions run at 115200 baud.
    localparam int CLKS_PER_BIT_DEFAULT = 434;

    localparam logic [7:0] ASCII_HASH = 8'h23;
    localparam logic [7:0] ASCII_DASH = 8'h2D;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_O    = 8'h4F;
    localparam logic [7:0] ASCII_P    = 8'h50;

    typedef enum logic {
        PARSE_COLLECT,
        PARSE_DISCARD
    } parse_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 receiver: two-flop synchronizer on the serial line, mid-bit
// sampling FSM, registered byte output with valid and framing-error pulses.
module uart_rx_core
    import bt_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    uart_state_t   state;
    logic [1:0]    sync;
    logic          line;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Preset to 1 so reset looks like an idle line, not a start bit.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], uart_rx};
        end
    end

    assign line = sync[1];

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!line) begin
                        state   <= START;
                        clk_cnt <= '0;
                        bit_idx <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= line ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        shift   <= {line, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (line) begin
                            rx_byte       <= shift;
                            rx_byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/bt_cmd_receiver.sv
// Bluetooth receive path: UART byte stream into a '#'-terminated frame parser
// that decodes "START-" and "STOP-" into single-cycle command pulses.
module bt_cmd_receiver
    import bt_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int MAX_LEN      = 10
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err,
    output logic       msg_done,
    output logic [3:0] msg_len,
    output logic       start_cmd,
    output logic       stop_cmd,
    output logic       overflow
);

    localparam logic [3:0] MAX_COUNT = 4'(MAX_LEN);

    parse_state_t state;
    logic [3:0]   count;
    logic [7:0]   frame_buf [MAX_LEN];
    logic         start_match;
    logic         stop_match;
    logic         is_hash;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .frame_err    (frame_err)
    );

    assign is_hash = (rx_byte == ASCII_HASH);

    // Gating on count keeps stale entries from older frames out of the match.
    always_comb begin
        start_match = (count == 4'd6) &&
                      frame_buf[0] == ASCII_S && frame_buf[1] == ASCII_T &&
                      frame_buf[2] == ASCII_A && frame_buf[3] == ASCII_R &&
                      frame_buf[4] == ASCII_T && frame_buf[5] == ASCII_DASH;
        stop_match  = (count == 4'd5) &&
                      frame_buf[0] == ASCII_S && frame_buf[1] == ASCII_T &&
                      frame_buf[2] == ASCII_O && frame_buf[3] == ASCII_P &&
                      frame_buf[4] == ASCII_DASH;
    end

    always_ff @(posedge clk_50M) begin
        if (rx_byte_valid && state == PARSE_COLLECT && !is_hash && count < MAX_COUNT) begin
            frame_buf[count] <= rx_byte;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state     <= PARSE_COLLECT;
            count     <= '0;
            msg_done  <= 1'b0;
            msg_len   <= '0;
            start_cmd <= 1'b0;
            stop_cmd  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            msg_done  <= 1'b0;
            start_cmd <= 1'b0;
            stop_cmd  <= 1'b0;
            overflow  <= 1'b0;
            unique case (state)
                PARSE_COLLECT: begin
                    if (frame_err) begin
                        count <= '0;
                    end else if (rx_byte_valid) begin
                        if (is_hash) begin
                            msg_done  <= 1'b1;
                            msg_len   <= count;
                            start_cmd <= start_match;
                            stop_cmd  <= stop_match;
                            count     <= '0;
                        end else if (count < MAX_COUNT) begin
                            count <= count + 4'd1;
                        end else begin
                            overflow <= 1'b1;
                            count    <= '0;
                            state    <= PARSE_DISCARD;
                        end
                    end
                end
                PARSE_DISCARD: begin
                    if (rx_byte_valid && is_hash) begin
                        count <= '0;
                        state <= PARSE_COLLECT;
                    end
                end
                default: state <= PARSE_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_bt_cmd_receiver.sv
// Self-checking bench for bt_cmd_receiver: serial stimulus compared against
// a frame-level reference model of the receive path.
module tb_bt_cmd_receiver;

    localparam int CPB     = 24;
    localparam int MAX_LEN = 10;

    logic       clk_50M = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       frame_err;
    logic       msg_done;
    logic [3:0] msg_len;
    logic       start_cmd;
    logic       stop_cmd;
    logic       overflow;

    always #10 clk_50M = ~clk_50M;

    bt_cmd_receiver #(
        .CLKS_PER_BIT(CPB),
        .MAX_LEN     (MAX_LEN)
    ) dut (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .rx_byte      (rx_byte),
        .rx_byte_valid(rx_byte_valid),
        .frame_err    (frame_err),
        .msg_done     (msg_done),
        .msg_len      (msg_len),
        .start_cmd    (start_cmd),
        .stop_cmd     (stop_cmd),
        .overflow     (overflow)
    );

    int checks = 0;
    int fails  = 0;

    int cyc = 0;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // Pulse counters observed on the DUT outputs, sampled mid-cycle.
    int got_valid = 0, got_ferr = 0, got_done = 0, got_ovf = 0;
    int got_start = 0, got_stop = 0, got_stray = 0;
    int valid_cyc = 0;
    int start_cyc = 0;

    always @(negedge clk_50M) begin
        if (rx_byte_valid) begin
            got_valid++;
            valid_cyc = cyc;
        end
        if (frame_err) got_ferr++;
        if (msg_done)  got_done++;
        if (overflow)  got_ovf++;
        if (start_cmd) got_start++;
        if (stop_cmd)  got_stop++;
        if ((start_cmd || stop_cmd) && !msg_done) got_stray++;
    end

    // Reference model: payload kept as a byte queue, compared as text on '#'.
    logic [7:0] payload[$];
    bit         discarding = 1'b0;
    int         exp_valid = 0, exp_ferr = 0, exp_done = 0, exp_ovf = 0;
    int         exp_start = 0, exp_stop = 0;
    logic [7:0] exp_last = 8'h00;
    int         exp_len = 0;

    function automatic string payload_text();
        string s = "";
        foreach (payload[i]) s = $sformatf("%s%c", s, payload[i]);
        return s;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_ferr++;
            if (!discarding) payload.delete();
            return;
        end
        exp_valid++;
        exp_last = b;
        if (discarding) begin
            if (b == 8'h23) discarding = 1'b0;
        end else if (b == 8'h23) begin
            exp_done++;
            exp_len = payload.size();
            if (payload_text() == "START-") exp_start++;
            if (payload_text() == "STOP-")  exp_stop++;
            payload.delete();
        end else if (payload.size() == MAX_LEN) begin
            exp_ovf++;
            discarding = 1'b1;
            payload.delete();
        end else begin
            payload.push_back(b);
        end
    endfunction

    function automatic void model_reset();
        payload.delete();
        discarding = 1'b0;
        exp_last   = 8'h00;
        exp_len    = 0;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic driveBit(input logic v);
        uart_rx = v;
        waitCycles(CPB);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit good);
        uart_rx   = 1'b0;
        start_cyc = cyc;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) driveBit(b[i]);
        if (good) begin
            driveBit(1'b1);
        end else begin
            // Low only across the stop-bit sample, then an idle bit to resync.
            uart_rx = 1'b0;
            waitCycles(CPB / 2 + 4);
            uart_rx = 1'b1;
            waitCycles(CPB - CPB / 2 - 4 + CPB);
        end
        model_byte(b, good);
    endtask

    task automatic sendString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".valid_count"}, got_valid, exp_valid);
        checkOutput({tag, ".ferr_count"},  got_ferr,  exp_ferr);
        checkOutput({tag, ".done_count"},  got_done,  exp_done);
        checkOutput({tag, ".ovf_count"},   got_ovf,   exp_ovf);
        checkOutput({tag, ".start_count"}, got_start, exp_start);
        checkOutput({tag, ".stop_count"},  got_stop,  exp_stop);
        checkOutput({tag, ".cmd_not_with_done"}, got_stray, 0);
        checkOutput({tag, ".rx_byte"},     32'(rx_byte), 32'(exp_last));
        checkOutput({tag, ".msg_len"},     32'(msg_len), exp_len);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".rx_byte"},       32'(rx_byte), 0);
        checkOutput({tag, ".rx_byte_valid"}, 32'(rx_byte_valid), 0);
        checkOutput({tag, ".frame_err"},     32'(frame_err), 0);
        checkOutput({tag, ".msg_done"},      32'(msg_done), 0);
        checkOutput({tag, ".msg_len"},       32'(msg_len), 0);
        checkOutput({tag, ".start_cmd"},     32'(start_cmd), 0);
        checkOutput({tag, ".stop_cmd"},      32'(stop_cmd), 0);
        checkOutput({tag, ".overflow"},      32'(overflow), 0);
    endtask

    function automatic logic [7:0] pick_char();
        string alpha = "STAROP-#xB";
        int    idx;
        if ($urandom_range(0, 4) == 0) return 8'($urandom);
        idx = $urandom_range(0, alpha.len() - 1);
        return alpha[idx];
    endfunction

    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    latency;
        string s;
        int    kind;
        int    len;
        rst     = 1'b1;
        uart_rx = 1'b1;
        waitCycles(5);
        checkAllZero("reset");
        rst = 1'b0;
        waitCycles(2 * CPB);

        // Single byte and its latency from the start-bit falling edge.
        applyStimulus(8'h53, 1'b1);
        latency = valid_cyc - start_cyc;
        checkOutput($sformatf("latency_%0d_in_window", latency),
                    32'((latency >= (19 * CPB) / 2) && (latency <= (19 * CPB) / 2 + 6)), 1);
        checkAll("byte53");
        applyStimulus(8'h23, 1'b1);
        checkAll("close53");

        sendString("START-#");
        checkAll("start");

        sendString("STOP-#");
        checkAll("stop");
        sendString("STAR#");
        checkAll("star");

        applyStimulus(8'h41, 1'b0);
        checkAll("bad_stop");
        sendString("STOP-#");
        checkAll("stop_after_ferr");

        sendString("AAAAAAAAAAA#");
        checkAll("overflow");
        sendString("START-#");
        checkAll("start_after_ovf");

        // Glitch shorter than half a bit must produce nothing.
        uart_rx = 1'b0;
        waitCycles(6);
        uart_rx = 1'b1;
        waitCycles(2 * CPB);
        checkAll("glitch");

        // Reset in the middle of the 'O' of "STOP-".
        sendString("ST");
        driveBit(1'b0);
        for (int i = 0; i < 3; i++) driveBit(8'h4F >> i);
        rst = 1'b1;
        waitCycles(3);
        checkAllZero("in_reset");
        uart_rx = 1'b1;
        rst     = 1'b0;
        model_reset();
        waitCycles(2 * CPB);
        checkAllZero("after_reset");
        checkAll("after_reset");
        sendString("STOP-#");
        checkAll("stop_after_reset");

        for (int f = 0; f < 10; f++) begin
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                s = "START-";
            end else if (kind == 1) begin
                s = "STOP-";
            end else begin
                s   = "";
                len = $urandom_range(0, 12);
                for (int i = 0; i < len; i++) s = $sformatf("%s%c", s, pick_char());
            end
            for (int i = 0; i < s.len(); i++) applyStimulus(s[i], $urandom_range(0, 15) != 0);
            applyStimulus(8'h23, 1'b1);
            checkAll($sformatf("random%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
